// File: rtl/tile_painter.sv
// rtl/tile_painter.sv - square tile rasteriser feeding the VGA adapter pixel-write port
//
// Purpose: takes one tile descriptor (origin, colour, erase) on start and emits
// 2^SIZE_LOG2 x 2^SIZE_LOG2 pixel writes in row-major order, one per clock,
// followed by a single-cycle done pulse.
//
// Optional build macro: TILE_BORDER_EN (1-pixel black outline on every tile).
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   paint request, sampled only while idle
//   x_in       in   [7:0] tile origin column
//   y_in       in   [6:0] tile origin row
//   colour_in  in   [2:0] tile colour
//   erase      in   paint every pixel black
//   x          out  [7:0] pixel column (registered)
//   y          out  [6:0] pixel row (registered)
//   colour     out  [2:0] pixel colour (registered)
//   plot       out  pixel-write strobe
//   busy       out  paint in progress
//   done       out  single-cycle pulse after the last pixel
module tile_painter #(
  parameter int SIZE_LOG2 = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       erase,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SIZE_LOG2-1:0] OFF_ONE = SIZE_LOG2'(1);
  localparam logic [SIZE_LOG2-1:0] OFF_MAX = '1;

  state_t               state_q, state_d;
  logic [7:0]           ox_q, ox_d;
  logic [6:0]           oy_q, oy_d;
  logic [2:0]           col_q, col_d;
  logic [SIZE_LOG2-1:0] dx_q, dx_d;
  logic [SIZE_LOG2-1:0] dy_q, dy_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [2:0]           colour_q, colour_d;
  logic                 plot_q, plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           pix_col;

  // Colour of the pixel at the current offset. Erase is already folded into
  // col_q at latch time, so only the outline needs handling here.
  always_comb begin
    pix_col = col_q;
`ifdef TILE_BORDER_EN
    if ((dx_q == '0) || (dx_q == OFF_MAX) || (dy_q == '0) || (dy_q == OFF_MAX)) begin
      pix_col = 3'b000;
    end
`endif
  end

  // Outputs are registered one stage behind the state, so busy/plot/done all
  // appear in the cycle after the state that produces them.
  always_comb begin
    state_d  = state_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    col_d    = col_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ox_d    = x_in;
          oy_d    = y_in;
          col_d   = erase ? 3'b000 : colour_in;
          dx_d    = '0;
          dy_d    = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        // 8-bit and 7-bit adds wrap naturally: no clipping at screen edges.
        x_d      = ox_q + 8'(dx_q);
        y_d      = oy_q + 7'(dy_q);
        colour_d = pix_col;
        plot_d   = 1'b1;
        dx_d     = dx_q + OFF_ONE;
        if (dx_q == OFF_MAX) begin
          dy_d = dy_q + OFF_ONE;
          if (dy_q == OFF_MAX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      col_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      col_q    <= col_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tile_painter.sv
// tb/tb_tile_painter.sv - scoreboard bench for tile_painter
module tb_tile_painter;

  localparam int EDGE = 8;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       erase;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  tile_painter #(.SIZE_LOG2(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .colour_in (colour_in),
    .erase     (erase),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_plot = -1;
  int k = 0;

  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pixel writes are matched in order against the scoreboard.
  always @(negedge clock) begin
    if (plot) begin
      if (plot_cnt == 0) first_plot = cyc;
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_plot", {x, y, colour}, 32'hFFFF_FFFF);
      end else begin
        chk("pixel", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_tile(input logic [7:0] ox, input logic [6:0] oy,
                           input logic [2:0] col, input logic er);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    for (int dy = 0; dy < EDGE; dy++) begin
      for (int dx = 0; dx < EDGE; dx++) begin
        px = ox + 8'(dx);
        py = oy + 7'(dy);
        pc = er ? 3'b000 : col;
`ifdef TILE_BORDER_EN
        if (dx == 0 || dy == 0 || dx == EDGE - 1 || dy == EDGE - 1) pc = 3'b000;
`endif
        exp_q.push_back({px, py, pc});
      end
    end
  endtask

  // Issues a one-cycle start and returns with start low; k is the sampling edge.
  task automatic kick(input logic [7:0] ox, input logic [6:0] oy,
                      input logic [2:0] col, input logic er);
    step();
    plot_cnt   = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    first_plot = -1;
    x_in = ox; y_in = oy; colour_in = col; erase = er;
    start = 1'b1;
    k = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic run_paint(input string tag, input logic [7:0] ox, input logic [6:0] oy,
                           input logic [2:0] col, input logic er, input bit pulses);
    push_tile(ox, oy, col, er);
    kick(ox, oy, col, er);
    while (done_cnt == 0 && (cyc - k) < 200) begin
      step();
      // Plot cycle 64 is also the cycle in which the FSM sits in DONE.
      if (pulses && ((cyc - k) == 10 || (cyc - k) == 64)) begin
        start = 1'b1; x_in = 8'd0; y_in = 7'd8; colour_in = 3'd7; erase = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_lat"}, done_cyc - k, 65);
    chk({tag, "_first_plot"}, first_plot - k, 1);
    chk({tag, "_plots"}, plot_cnt, 64);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    repeat (3) step();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; x_in = 8'd5; y_in = 7'd5; colour_in = 3'd7; erase = 1'b0;

    // Reset held with start high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_xyc", {x, y, colour}, 0);
    end
    start = 1'b0;
    resetn = 1'b1;
    repeat (4) step();
    chk("idle_busy", busy, 0);
    chk("idle_plots", plot_cnt, 0);

    run_paint("basic", 8'd8, 7'd0, 3'b010, 1'b0, 1'b0);
    run_paint("ignore", 8'd8, 7'd0, 3'b010, 1'b0, 1'b1);
    repeat (80) step();
    chk("ignore_no_second", plot_cnt, 64);
    chk("ignore_idle", busy, 0);

    run_paint("erase", 8'd0, 7'd8, 3'b100, 1'b1, 1'b0);
    run_paint("wrap", 8'd252, 7'd124, 3'b110, 1'b0, 1'b0);

    // Reset after the 20th pixel: outputs must fall without a clock edge.
    push_tile(8'd0, 7'd8, 3'b101, 1'b0);
    kick(8'd0, 7'd8, 3'b101, 1'b0);
    while (plot_cnt < 20 && (cyc - k) < 200) step();
    chk("mid_plot_cnt", plot_cnt, 20);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    step();
    resetn = 1'b1;
    step();
    run_paint("fresh", 8'd0, 7'd0, 3'b011, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
